spi_slave_core: RTL and testbench

- SPI peripheral (slave) endpoint. It is the far end of the settings-bus SPI master in the same link.
- Oversamples the external sclk/sen/mosi on the fabric clock.
- Shifts out a word loaded over the 32-bit settings bus and captures the word clocked in on mosi.
- Presents the captured word on readback with a one-cycle strobe when the frame ends.
- Used for board-to-board and loopback links inside the lab system.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_slave_sync.sv | 36 +++
 rtl/spi_slave_core.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, settings-bus register offsets
// and small helpers used by the SPI slave (and master) cores.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_DONE      = 2'd3
  } spi_state_e;

  // Register offsets relative to the block's settings-bus base address.
  localparam logic [7:0] SPI_REG_TX_DATA = 8'd0;

  // Received-bit counter saturates here so very long frames stay readable.
  localparam logic [5:0] SPI_BITS_MAX = 6'd63;

  // Saturating increment of the 6-bit received-bit counter.
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    logic [5:0] r;
    if (v == SPI_BITS_MAX) begin
      r = v;
    end else begin
      r = v + 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin plus a history flop
// that yields single-cycle rise/fall pulses on the synchronized level.
module spi_slave_sync #(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  // Synchronize the pin and keep one cycle of history; reset to the idle level
  // so no spurious edge is seen when reset releases.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= IDLE_VAL;
      r_sync <= IDLE_VAL;
      r_hist <= IDLE_VAL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_hist;
  assign o_fall  = ~r_sync & r_hist;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave endpoint: oversamples sclk/sen/mosi on the fabric clock, shifts
// out a word loaded over the settings bus and captures the word on mosi,
// presenting it on readback with a one-cycle strobe at frame end.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter logic [7:0]  BASE     = 8'h00,
  parameter logic        CLK_IDLE = 1'b0,
  parameter logic        CPHA     = 1'b0,
  parameter logic [31:0] TX_FILL  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [31:0] readback,
  output logic [5:0]  readback_bits,
  output logic        readback_stb,
  output logic        tx_underrun,
  output logic        busy,
  input  logic        sclk,
  input  logic        sen,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe
);

  localparam logic [7:0] TX_ADDR = BASE + SPI_REG_TX_DATA;

  spi_state_e r_state;
  spi_state_e w_state_nxt;

  logic        w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic        w_sen_level,  w_sen_rise,  w_sen_fall;
  logic        w_mosi_level, w_mosi_rise, w_mosi_fall;
  logic        w_unused_mosi_edges;
  logic        w_sclk_edge, w_lead, w_trail;
  logic        w_start, w_sample, w_shift, w_done;
  logic        w_tx_write;
  logic [31:0] w_load_word;

  logic [1:0]  r_settle;
  logic [31:0] r_tx_word;
  logic        r_tx_fresh;
  logic [31:0] r_shift;
  logic [31:0] r_rx;
  logic [5:0]  r_bit_cnt;
  logic        r_first;
  logic        r_miso;
  logic        r_miso_oe;
  logic        r_busy;
  logic        r_underrun;
  logic [31:0] r_readback;
  logic [5:0]  r_readback_bits;
  logic        r_readback_stb;

  spi_slave_sync #(.IDLE_VAL(CLK_IDLE)) u_sync_sclk (
    .i_clk(clock), .i_reset_n(reset), .i_pin(sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_slave_sync #(.IDLE_VAL(1'b1)) u_sync_sen (
    .i_clk(clock), .i_reset_n(reset), .i_pin(sen),
    .o_level(w_sen_level), .o_rise(w_sen_rise), .o_fall(w_sen_fall)
  );

  spi_slave_sync #(.IDLE_VAL(1'b0)) u_sync_mosi (
    .i_clk(clock), .i_reset_n(reset), .i_pin(mosi),
    .o_level(w_mosi_level), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  // mosi is only ever sampled as a level; its edge pulses have no use here.
  assign w_unused_mosi_edges = w_mosi_rise | w_mosi_fall;

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
  assign w_lead      = w_sclk_edge & (w_sclk_level != CLK_IDLE);
  assign w_trail     = w_sclk_edge & (w_sclk_level == CLK_IDLE);

  assign w_tx_write  = set_stb & (set_addr == TX_ADDR);
  assign w_load_word = r_tx_fresh ? r_tx_word : TX_FILL;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_WAIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: begin
        // Let the synchronizers fill with real pin values before trusting sen,
        // so a frame already running at reset release is not picked up.
        if ((r_settle == 2'd3) && w_sen_level) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_sen_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // End of frame wins over any sclk edge seen in the same cycle.
        if (w_sen_rise) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_sample = CPHA ? w_trail : w_lead;
          w_shift  = CPHA ? w_lead  : w_trail;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_WAIT_IDLE;
      end
    endcase
  end

  // Post-reset settle counter used only while waiting for an idle bus.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_settle <= 2'd0;
    end else if ((r_state == ST_WAIT_IDLE) && (r_settle != 2'd3)) begin
      r_settle <= r_settle + 2'd1;
    end else begin
      r_settle <= r_settle;
    end
  end

  // Tx data register; a write in the frame-start cycle stays fresh for the next frame.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tx_word  <= 32'h0000_0000;
      r_tx_fresh <= 1'b0;
    end else if (w_tx_write) begin
      r_tx_word  <= set_data;
      r_tx_fresh <= 1'b1;
    end else if (w_start) begin
      r_tx_fresh <= 1'b0;
    end else begin
      r_tx_fresh <= r_tx_fresh;
    end
  end

  // Shift/capture datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_shift         <= 32'h0000_0000;
      r_rx            <= 32'h0000_0000;
      r_bit_cnt       <= 6'd0;
      r_first         <= 1'b0;
      r_miso          <= 1'b0;
      r_miso_oe       <= 1'b0;
      r_busy          <= 1'b0;
      r_underrun      <= 1'b0;
      r_readback      <= 32'h0000_0000;
      r_readback_bits <= 6'd0;
      r_readback_stb  <= 1'b0;
    end else begin
      r_readback_stb <= 1'b0;
      r_busy         <= (w_state_nxt == ST_ACTIVE);
      if (w_start) begin
        r_shift   <= w_load_word;
        r_rx      <= 32'h0000_0000;
        r_bit_cnt <= 6'd0;
        r_first   <= 1'b1;
        r_miso_oe <= 1'b1;
        // With CPHA=0 the first bit must be on miso before the first sample edge.
        r_miso    <= CPHA ? 1'b0 : w_load_word[31];
        if (!r_tx_fresh) begin
          r_underrun <= 1'b1;
        end
      end else if (w_sample) begin
        r_rx      <= {r_rx[30:0], w_mosi_level};
        r_bit_cnt <= sat_inc6(r_bit_cnt);
      end else if (w_shift) begin
        if (CPHA && r_first) begin
          r_miso  <= r_shift[31];
          r_first <= 1'b0;
        end else begin
          r_shift <= {r_shift[30:0], 1'b0};
          r_miso  <= r_shift[30];
        end
      end else if (w_done) begin
        r_miso_oe <= 1'b0;
        r_miso    <= 1'b0;
        if (r_bit_cnt != 6'd0) begin
          r_readback      <= r_rx;
          r_readback_bits <= r_bit_cnt;
          r_readback_stb  <= 1'b1;
        end
      end
    end
  end

  assign readback      = r_readback;
  assign readback_bits = r_readback_bits;
  assign readback_stb  = r_readback_stb;
  assign tx_underrun   = r_underrun;
  assign busy          = r_busy;
  assign miso          = r_miso;
  assign miso_oe       = r_miso_oe;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: two instances (mode 0 with a
// DEADBEEF fill word, mode 3 at a different base), a frame-level model and a
// per-cycle compare process, plus hand-computed literal expectations.
module tb_spi_slave_core;

  localparam int H = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'h00;
  logic [31:0] set_data = 32'h0;

  logic a_sclk = 1'b0, a_sen = 1'b1, a_mosi = 1'b0;
  logic b_sclk = 1'b1, b_sen = 1'b1, b_mosi = 1'b0;
  logic [31:0] a_rb, b_rb;
  logic [5:0]  a_bits, b_bits;
  logic a_stb, a_und, a_busy, a_miso, a_oe;
  logic b_stb, b_und, b_busy, b_miso, b_oe;

  spi_slave_core #(.BASE(8'h00), .CLK_IDLE(1'b0), .CPHA(1'b0), .TX_FILL(32'hDEAD_BEEF)) dut_a (
    .clock(clock), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .readback(a_rb), .readback_bits(a_bits), .readback_stb(a_stb), .tx_underrun(a_und),
    .busy(a_busy), .sclk(a_sclk), .sen(a_sen), .mosi(a_mosi), .miso(a_miso), .miso_oe(a_oe));

  spi_slave_core #(.BASE(8'h10), .CLK_IDLE(1'b1), .CPHA(1'b1), .TX_FILL(32'h0000_0000)) dut_b (
    .clock(clock), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .readback(b_rb), .readback_bits(b_bits), .readback_stb(b_stb), .tx_underrun(b_und),
    .busy(b_busy), .sclk(b_sclk), .sen(b_sen), .mosi(b_mosi), .miso(b_miso), .miso_oe(b_oe));

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  // Frame-level model, one slot per instance.
  logic [31:0] m_word [2];
  logic [31:0] m_fill [2];
  logic        m_fresh [2];
  logic        m_und [2];
  logic [31:0] m_rb [2];
  logic [5:0]  m_bits [2];
  logic        m_valid [2];
  int          stb_cnt [2];
  logic [37:0] exp_q0 [$];
  logic [37:0] exp_q1 [$];

  int   rst_quiet = 0;
  int   quiet [2];
  logic last_sen [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_sclk(input int k, input logic v);
    if (k == 0) a_sclk = v; else b_sclk = v;
  endtask
  task automatic set_sen(input int k, input logic v);
    if (k == 0) a_sen = v; else b_sen = v;
  endtask
  task automatic set_mosi(input int k, input logic v);
    if (k == 0) a_mosi = v; else b_mosi = v;
  endtask
  function automatic logic get_miso(input int k);
    return (k == 0) ? a_miso : b_miso;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fresh[k] = 1'b0; m_und[k] = 1'b0; m_rb[k] = 32'h0;
      m_bits[k] = 6'd0; m_valid[k] = 1'b0; m_word[k] = 32'h0;
    end
  endtask

  // Returns the word the slave must shift out for a frame starting now.
  task automatic model_start(input int k, output logic [31:0] tx);
    tx = m_fresh[k] ? m_word[k] : m_fill[k];
    if (!m_fresh[k]) m_und[k] = 1'b1;
    m_fresh[k] = 1'b0;
    m_valid[k] = 1'b1;
  endtask

  task automatic model_write(input int k, input logic [31:0] d);
    m_word[k] = d;
    m_fresh[k] = 1'b1;
  endtask

  task automatic write_tx(input int k, input logic [31:0] d);
    @(negedge clock);
    set_stb = 1'b1; set_addr = (k == 0) ? 8'h00 : 8'h10; set_data = d;
    @(negedge clock);
    set_stb = 1'b0;
    model_write(k, d);
  endtask

  task automatic check_reset_state();
    chk("rst_a_rb", {32'h0, a_rb}, 64'h0);
    chk("rst_a_bits", {58'h0, a_bits}, 64'h0);
    chk("rst_a_flags", {59'h0, a_stb, a_und, a_busy, a_miso, a_oe}, 64'h0);
    chk("rst_b_rb", {32'h0, b_rb}, 64'h0);
    chk("rst_b_bits", {58'h0, b_bits}, 64'h0);
    chk("rst_b_flags", {59'h0, b_stb, b_und, b_busy, b_miso, b_oe}, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    wait_clk(3);
    check_reset_state();
    reset = 1'b1;
  endtask

  // Master side of one frame. abort_at != 0 resets the link before that bit
  // while sen stays low. co_en writes co_word in the cycle the frame starts.
  task automatic spi_frame(input int k, input int nbits, input logic [63:0] data,
                           input int abort_at, input logic co_en, input logic [31:0] co_word,
                           output logic [63:0] got);
    logic cpol, cpha, b, aborted;
    logic [31:0] tx;
    logic [63:0] mask, masked;
    cpol = (k == 1); cpha = (k == 1); aborted = 1'b0; got = 64'h0;
    @(negedge clock);
    set_sen(k, 1'b0);
    model_start(k, tx);
    if (!cpha && nbits > 0) set_mosi(k, data[nbits-1]);
    if (co_en) begin
      wait_clk(2);
      set_stb = 1'b1; set_addr = (k == 0) ? 8'h00 : 8'h10; set_data = co_word;
      wait_clk(1);
      set_stb = 1'b0;
      model_write(k, co_word);
      wait_clk(H - 3);
    end else begin
      wait_clk(H);
    end
    for (int i = 0; i < nbits; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        do_reset();
        aborted = 1'b1;
        break;
      end
      set_sclk(k, !cpol);
      if (cpha) set_mosi(k, data[nbits-1-i]);
      else begin
        b = get_miso(k); got = {got[62:0], b};
        chk("miso_bit", {63'h0, b}, {63'h0, (i < 32) ? tx[31-i] : 1'b0});
      end
      wait_clk(H);
      set_sclk(k, cpol);
      if (cpha) begin
        b = get_miso(k); got = {got[62:0], b};
        chk("miso_bit", {63'h0, b}, {63'h0, (i < 32) ? tx[31-i] : 1'b0});
      end else if (i + 1 < nbits) set_mosi(k, data[nbits-2-i]);
      wait_clk(H);
    end
    if (aborted) begin
      wait_clk(20);
      set_sen(k, 1'b1);
      wait_clk(20);
    end else begin
      set_sen(k, 1'b1);
      if (nbits > 0) begin
        mask = (64'd1 << nbits) - 64'd1;
        masked = (nbits >= 32) ? data : (data & mask);
        m_rb[k] = masked[31:0];
        m_bits[k] = (nbits > 63) ? 6'd63 : nbits[5:0];
        if (k == 0) exp_q0.push_back({m_bits[k], m_rb[k]});
        else exp_q1.push_back({m_bits[k], m_rb[k]});
      end
      wait_clk(H + 6);
    end
  endtask

  task automatic cmp_inst(input int k, input logic stb, input logic [31:0] rb, input logic [5:0] bits,
                          input logic und, input logic bsy, input logic oe, input logic mi,
                          input logic sen_pin, input int q);
    logic [37:0] e;
    if (stb) begin
      stb_cnt[k]++;
      if (k == 0 && exp_q0.size() > 0) begin
        e = exp_q0.pop_front(); chk("strobe_data", {26'h0, bits, rb}, {26'h0, e});
      end else if (k == 1 && exp_q1.size() > 0) begin
        e = exp_q1.pop_front(); chk("strobe_data", {26'h0, bits, rb}, {26'h0, e});
      end else begin
        chk("unexpected_strobe", {63'h0, stb}, 64'h0);
      end
    end
    if (rst_quiet >= 8 && q >= 8) begin
      if (sen_pin) begin
        chk("idle_flags", {61'h0, bsy, oe, mi}, 64'h0);
        chk("underrun", {63'h0, und}, {63'h0, m_und[k]});
        chk("readback_hold", {26'h0, bits, rb}, {26'h0, m_bits[k], m_rb[k]});
      end else if (m_valid[k]) begin
        chk("active_flags", {62'h0, bsy, oe}, 64'h3);
      end else begin
        chk("ignored_frame_flags", {62'h0, bsy, oe}, 64'h0);
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (!reset) rst_quiet = 0; else if (rst_quiet < 1000) rst_quiet++;
    if (a_sen != last_sen[0]) quiet[0] = 0; else if (quiet[0] < 1000) quiet[0]++;
    if (b_sen != last_sen[1]) quiet[1] = 0; else if (quiet[1] < 1000) quiet[1]++;
    last_sen[0] = a_sen;
    last_sen[1] = b_sen;
    if (reset) begin
      cmp_inst(0, a_stb, a_rb, a_bits, a_und, a_busy, a_oe, a_miso, a_sen, quiet[0]);
      cmp_inst(1, b_stb, b_rb, b_bits, b_und, b_busy, b_oe, b_miso, b_sen, quiet[1]);
    end
  end

  initial begin
    logic [63:0] got;
    int s0;
    quiet[0] = 0; quiet[1] = 0; last_sen[0] = 1'b1; last_sen[1] = 1'b1;
    stb_cnt[0] = 0; stb_cnt[1] = 0;
    m_fill[0] = 32'hDEAD_BEEF; m_fill[1] = 32'h0000_0000;
    model_reset();

    wait_clk(5);
    check_reset_state();
    reset = 1'b1;
    wait_clk(12);

    // Mode 0, fresh word, 32-bit frame.
    write_tx(0, 32'hA5C3_0F96);
    s0 = stb_cnt[0];
    spi_frame(0, 32, 64'h1234_5678, 0, 1'b0, 32'h0, got);
    chk("t1_miso_word", got, 64'hA5C3_0F96);
    chk("t1_readback", {32'h0, a_rb}, 64'h1234_5678);
    chk("t1_bits", {58'h0, a_bits}, 64'd32);
    chk("t1_strobes", 64'(stb_cnt[0] - s0), 64'd1);
    chk("t1_underrun", {63'h0, a_und}, 64'h0);

    // No fresh word: fill goes out and underrun becomes sticky.
    spi_frame(0, 8, 64'h3C, 0, 1'b0, 32'h0, got);
    chk("t2_miso_word", got, 64'hDE);
    chk("t2_readback", {32'h0, a_rb}, 64'h0000_003C);
    chk("t2_bits", {58'h0, a_bits}, 64'd8);
    chk("t2_underrun", {63'h0, a_und}, 64'h1);
    write_tx(0, 32'h1111_2222);
    spi_frame(0, 16, 64'h00FF, 0, 1'b0, 32'h0, got);
    chk("t2b_miso_word", got, 64'h1111);
    chk("t2b_underrun_sticky", {63'h0, a_und}, 64'h1);

    // Mode 3 at base 0x10.
    write_tx(1, 32'hCAFE_0000);
    spi_frame(1, 16, 64'hBEEF, 0, 1'b0, 32'h0, got);
    chk("t3_miso_word", got, 64'hCAFE);
    chk("t3_readback", {32'h0, b_rb}, 64'h0000_BEEF);
    chk("t3_bits", {58'h0, b_bits}, 64'd16);
    chk("t3_underrun", {63'h0, b_und}, 64'h0);

    // Write coinciding with frame start: old state used, new word kept for next frame.
    spi_frame(1, 8, 64'hA5, 0, 1'b1, 32'h1357_9BDF, got);
    chk("t3c_miso_fill", got, 64'h00);
    chk("t3c_underrun", {63'h0, b_und}, 64'h1);
    spi_frame(1, 8, 64'h5A, 0, 1'b0, 32'h0, got);
    chk("t3d_miso_word", got, 64'h13);
    chk("t3d_readback", {32'h0, b_rb}, 64'h0000_005A);

    // sen pulse without sclk edges: no strobe.
    s0 = stb_cnt[0];
    spi_frame(0, 0, 64'h0, 0, 1'b0, 32'h0, got);
    wait_clk(10);
    chk("t4_no_strobe", 64'(stb_cnt[0] - s0), 64'd0);
    chk("t4_busy", {62'h0, a_busy, a_oe}, 64'h0);

    // 40-bit overrun frame.
    write_tx(0, 32'h0F0F_F0F0);
    spi_frame(0, 40, 64'hFF_FFFF_FFFF, 0, 1'b0, 32'h0, got);
    chk("t5_miso_word", got, 64'h0F_0FF0_F000);
    chk("t5_readback", {32'h0, a_rb}, 64'hFFFF_FFFF);
    chk("t5_bits", {58'h0, a_bits}, 64'd40);

    // Reset in mid-frame, released while sen is low.
    write_tx(0, 32'h00AB_CDEF);
    s0 = stb_cnt[0];
    spi_frame(0, 24, 64'hC0FFEE, 10, 1'b0, 32'h0, got);
    chk("t6_no_strobe", 64'(stb_cnt[0] - s0), 64'd0);
    chk("t6_underrun_cleared", {63'h0, a_und}, 64'h0);
    write_tx(0, 32'h5A5A_5A5A);
    spi_frame(0, 24, 64'hC0FFEE, 0, 1'b0, 32'h0, got);
    chk("t6_miso_word", got, 64'h5A5A5A);
    chk("t6_readback", {32'h0, a_rb}, 64'h00C0_FFEE);
    chk("t6_bits", {58'h0, a_bits}, 64'd24);

    wait_clk(10);
    chk("pending_strobes", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
